divisor_segmentado_gen: RTL and testbench

DIVISOR_SEGMENTADO_GEN -- requirements
Module: divisor_segmentado_gen

---
 rtl/divisor_segmentado_gen.sv | 140 ++++++++++++++
 tb/tb_divisor_segmentado_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_segmentado_gen.sv
// Pipelined restoring divider: one operation accepted per enabled cycle, signed or unsigned per operation.
// One input register, TAMANYO restoring stages, one output register carrying sign fix-up and exceptions.
module divisor_segmentado_gen #(
    parameter int TAMANYO = 32,
    parameter int TAG_W   = 4
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               ENABLE,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [TAMANYO-1:0] Num,
    input  logic [TAMANYO-1:0] Den,
    input  logic [TAG_W-1:0]   TAG_IN,
    output logic               Done,
    output logic [TAMANYO-1:0] Coc,
    output logic [TAMANYO-1:0] Res,
    output logic               DIV0,
    output logic               OVF,
    output logic [TAG_W-1:0]   TAG_OUT,
    output logic               BUSY
);

    localparam logic [TAMANYO-1:0] MOST_NEG = {1'b1, {(TAMANYO-1){1'b0}}};

    // Index 0 is the input register; index s holds the state after restoring step s.
    logic [TAMANYO:0]   valid;
    logic [TAMANYO-1:0] accu   [0:TAMANYO];
    logic [TAMANYO-1:0] quot   [0:TAMANYO];
    logic [TAMANYO-1:0] dvsr   [0:TAMANYO];
    logic [TAMANYO-1:0] num_og [0:TAMANYO];
    logic [TAG_W-1:0]   tag    [0:TAMANYO];
    logic [TAMANYO:0]   neg_q;
    logic [TAMANYO:0]   neg_r;
    logic [TAMANYO:0]   div0_f;
    logic [TAMANYO:0]   ovf_f;

    logic [TAMANYO:0]   shifted  [1:TAMANYO];
    logic [TAMANYO:0]   trial    [1:TAMANYO];
    logic [TAMANYO-1:0] accu_nxt [1:TAMANYO];
    logic [TAMANYO-1:0] quot_nxt [1:TAMANYO];

    logic               num_neg;
    logic               den_neg;
    logic [TAMANYO-1:0] num_mag;
    logic [TAMANYO-1:0] den_mag;
    logic [TAMANYO-1:0] coc_fix;
    logic [TAMANYO-1:0] res_fix;

    // The most-negative operand negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        num_neg = SIGNED_MODE & Num[TAMANYO-1];
        den_neg = SIGNED_MODE & Den[TAMANYO-1];
        num_mag = num_neg ? -Num : Num;
        den_mag = den_neg ? -Den : Den;
    end

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        for (int s = 1; s <= TAMANYO; s++) begin
            shifted[s] = {accu[s-1], quot[s-1][TAMANYO-1]};
            trial[s]   = shifted[s] - {1'b0, dvsr[s-1]};
            if (!trial[s][TAMANYO]) begin
                accu_nxt[s] = trial[s][TAMANYO-1:0];
                quot_nxt[s] = {quot[s-1][TAMANYO-2:0], 1'b1};
            end else begin
                accu_nxt[s] = shifted[s][TAMANYO-1:0];
                quot_nxt[s] = {quot[s-1][TAMANYO-2:0], 1'b0};
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only ever consumed behind a valid bit that is reset.
    always_ff @(posedge CLK) begin
        if (ENABLE) begin
            if (START) begin
                accu[0]   <= '0;
                quot[0]   <= num_mag;
                dvsr[0]   <= den_mag;
                num_og[0] <= Num;
                tag[0]    <= TAG_IN;
                neg_q[0]  <= num_neg ^ den_neg;
                neg_r[0]  <= num_neg;
                div0_f[0] <= (Den == '0);
                ovf_f[0]  <= SIGNED_MODE && (Num == MOST_NEG) && (Den == '1);
            end
            for (int s = 1; s <= TAMANYO; s++) begin
                if (valid[s-1]) begin
                    accu[s]   <= accu_nxt[s];
                    quot[s]   <= quot_nxt[s];
                    dvsr[s]   <= dvsr[s-1];
                    num_og[s] <= num_og[s-1];
                    tag[s]    <= tag[s-1];
                    neg_q[s]  <= neg_q[s-1];
                    neg_r[s]  <= neg_r[s-1];
                    div0_f[s] <= div0_f[s-1];
                    ovf_f[s]  <= ovf_f[s-1];
                end
            end
        end
    end

    // Exceptions override the magnitude result: Den=0 returns the dividend untouched.
    always_comb begin
        coc_fix = neg_q[TAMANYO] ? -quot[TAMANYO] : quot[TAMANYO];
        res_fix = neg_r[TAMANYO] ? -accu[TAMANYO] : accu[TAMANYO];
        if (div0_f[TAMANYO]) begin
            coc_fix = '1;
            res_fix = num_og[TAMANYO];
        end else if (ovf_f[TAMANYO]) begin
            coc_fix = MOST_NEG;
            res_fix = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            valid   <= '0;
            Done    <= 1'b0;
            Coc     <= '0;
            Res     <= '0;
            DIV0    <= 1'b0;
            OVF     <= 1'b0;
            TAG_OUT <= '0;
        end else if (ENABLE) begin
            valid <= {valid[TAMANYO-1:0], START};
            Done  <= valid[TAMANYO];
            if (valid[TAMANYO]) begin
                Coc     <= coc_fix;
                Res     <= res_fix;
                DIV0    <= div0_f[TAMANYO];
                OVF     <= ovf_f[TAMANYO] & ~div0_f[TAMANYO];
                TAG_OUT <= tag[TAMANYO];
            end
        end
    end

    assign BUSY = (|valid) | Done;

endmodule

// File: tb/tb_divisor_segmentado_gen.sv
// Directed and random bench for divisor_segmentado_gen at TAMANYO=8, TAG_W=4.
// Expected results and completion cycles are queued at issue time and matched as Done appears.
module tb_divisor_segmentado_gen;

    localparam int T = 8;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RSTa, ENABLE, START, SIGNED_MODE;
    logic [T-1:0] Num, Den;
    logic [W-1:0] TAG_IN;
    logic         Done, DIV0, OVF, BUSY;
    logic [T-1:0] Coc, Res;
    logic [W-1:0] TAG_OUT;

    divisor_segmentado_gen #(.TAMANYO(T), .TAG_W(W)) dut (
        .CLK(CLK), .RSTa(RSTa), .ENABLE(ENABLE), .START(START), .SIGNED_MODE(SIGNED_MODE),
        .Num(Num), .Den(Den), .TAG_IN(TAG_IN), .Done(Done), .Coc(Coc), .Res(Res),
        .DIV0(DIV0), .OVF(OVF), .TAG_OUT(TAG_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] coc;
        logic [7:0] res;
        logic       div0;
        logic       ovf;
        logic [3:0] tag;
    } exp_t;

    exp_t sb[$];
    int   exp_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic mode, input logic [7:0] n, input logic [7:0] d,
                                   input logic [3:0] t);
        exp_t e;
        int   a, b, q, r;
        e.tag  = t;
        e.div0 = 1'b0;
        e.ovf  = 1'b0;
        if (d == 8'h00) begin
            e.div0 = 1'b1;
            e.coc  = 8'hFF;
            e.res  = n;
        end else if (mode && n == 8'h80 && d == 8'hFF) begin
            e.ovf = 1'b1;
            e.coc = 8'h80;
            e.res = 8'h00;
        end else begin
            if (mode) begin
                a = $signed(n);
                b = $signed(d);
            end else begin
                a = int'(n);
                b = int'(d);
            end
            q = a / b;
            r = a % b;
            e.coc = q[7:0];
            e.res = r[7:0];
        end
        return e;
    endfunction

    // Each Done seen on an enabled, non-reset edge retires the oldest queued expectation.
    always @(posedge CLK) begin : monitor
        logic en_s, rst_s;
        exp_t e;
        int   ec;
        cyc++;
        en_s  = ENABLE;
        rst_s = RSTa;
        #1;
        if (Done === 1'b1 && en_s && !rst_s) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                e  = sb.pop_front();
                ec = exp_cyc.pop_front();
                chk("coc", 32'(Coc), 32'(e.coc));
                chk("res", 32'(Res), 32'(e.res));
                chk("flags", 32'({DIV0, OVF}), 32'({e.div0, e.ovf}));
                chk("tag", 32'(TAG_OUT), 32'(e.tag));
                chk("done_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    task automatic drive(input logic mode, input logic [7:0] n, input logic [7:0] d,
                         input logic [3:0] t);
        @(negedge CLK);
        START       = 1'b1;
        SIGNED_MODE = mode;
        Num         = n;
        Den         = d;
        TAG_IN      = t;
    endtask

    // The issue edge is the next posedge, so Done is visible T+1 edges after it.
    task automatic send(input logic mode, input logic [7:0] n, input logic [7:0] d,
                        input logic [3:0] t, input exp_t e, input int extra);
        drive(mode, n, d, t);
        sb.push_back(e);
        exp_cyc.push_back(cyc + T + 2 + extra);
    endtask

    task automatic idle();
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge CLK);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin : stim
        logic       m;
        logic [7:0] n, d;
        int         k;

        RSTa = 1'b1; ENABLE = 1'b1; START = 1'b0; SIGNED_MODE = 1'b0;
        Num = '0; Den = '0; TAG_IN = '0;
        repeat (3) @(negedge CLK);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_coc", 32'(Coc), 32'd0);
        chk("rst_res", 32'(Res), 32'd0);
        chk("rst_flags", 32'({DIV0, OVF}), 32'd0);
        chk("rst_tag", 32'(TAG_OUT), 32'd0);
        RSTa = 1'b0;

        // Single operation: 100/7 with tag 3, then Done must drop after one cycle.
        send(1'b0, 8'd100, 8'd7, 4'd3, '{8'd14, 8'd2, 1'b0, 1'b0, 4'd3}, 0);
        idle();
        wait_drain(20);
        @(posedge CLK); #1;
        chk("done_pulse", 32'(Done), 32'd0);
        chk("busy_idle", 32'(BUSY), 32'd0);

        // Sign handling and exceptions, issued back to back.
        send(1'b1, 8'hF9, 8'h02, 4'd1, '{8'hFD, 8'hFF, 1'b0, 1'b0, 4'd1}, 0);
        send(1'b1, 8'h07, 8'hFE, 4'd2, '{8'hFD, 8'h01, 1'b0, 1'b0, 4'd2}, 0);
        send(1'b0, 8'hF9, 8'h02, 4'd3, '{8'd124, 8'h01, 1'b0, 1'b0, 4'd3}, 0);
        send(1'b1, 8'h80, 8'hFF, 4'd4, '{8'h80, 8'h00, 1'b0, 1'b1, 4'd4}, 0);
        send(1'b0, 8'd55, 8'h00, 4'd5, '{8'hFF, 8'd55, 1'b1, 1'b0, 4'd5}, 0);
        send(1'b1, 8'd55, 8'h00, 4'd6, '{8'hFF, 8'd55, 1'b1, 1'b0, 4'd6}, 0);
        send(1'b1, 8'hC9, 8'h00, 4'd7, '{8'hFF, 8'hC9, 1'b1, 1'b0, 4'd7}, 0);
        send(1'b0, 8'h80, 8'hFF, 4'd8, '{8'h00, 8'h80, 1'b0, 1'b0, 4'd8}, 0);
        send(1'b1, 8'h80, 8'h01, 4'd9, '{8'h80, 8'h00, 1'b0, 1'b0, 4'd9}, 0);
        idle();
        wait_drain(30);

        // Twenty back-to-back random operations in mixed modes.
        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom_range(0, 1));
            n = 8'($urandom);
            d = 8'($urandom);
            send(m, n, d, 4'(i), model(m, n, d, 4'(i)), 0);
        end
        idle();
        wait_drain(40);

        // ENABLE low for five edges with one operation in flight; the ignored START must not queue.
        send(1'b0, 8'hFF, 8'h10, 4'hB, '{8'h0F, 8'h0F, 1'b0, 1'b0, 4'hB}, 5);
        idle();
        repeat (2) @(negedge CLK);
        ENABLE = 1'b0; START = 1'b1; Num = 8'h33; Den = 8'h03; TAG_IN = 4'hF;
        repeat (5) @(negedge CLK);
        ENABLE = 1'b1; START = 1'b0;
        wait_drain(30);

        // ENABLE low while Done is high: outputs hold for five edges.
        send(1'b0, 8'd9, 8'd4, 4'hC, '{8'h02, 8'h01, 1'b0, 1'b0, 4'hC}, 0);
        send(1'b0, 8'd50, 8'd5, 4'hD, '{8'h0A, 8'h00, 1'b0, 1'b0, 4'hD}, 5);
        send(1'b1, 8'hEC, 8'd3, 4'hE, '{8'hFA, 8'hFE, 1'b0, 1'b0, 4'hE}, 5);
        idle();
        k = 0;
        while (k < 20 && Done !== 1'b1) begin
            @(negedge CLK);
            k++;
        end
        chk("wait_done", 32'(Done), 32'd1);
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("freeze_done", 32'(Done), 32'd1);
            chk("freeze_coc", 32'(Coc), 32'h02);
            chk("freeze_tag", 32'(TAG_OUT), 32'hC);
        end
        @(negedge CLK);
        ENABLE = 1'b1;
        wait_drain(30);

        // Reset with six operations in flight: none may complete.
        for (int i = 0; i < 6; i++) drive(1'b0, 8'($urandom), 8'($urandom_range(1, 255)), 4'(i));
        @(negedge CLK);
        START = 1'b0; RSTa = 1'b1;
        @(posedge CLK); #1;
        chk("rst2_busy", 32'(BUSY), 32'd0);
        chk("rst2_done", 32'(Done), 32'd0);
        chk("rst2_coc", 32'(Coc), 32'd0);
        @(negedge CLK);
        RSTa = 1'b0;
        repeat (15) @(negedge CLK);
        send(1'b0, 8'd200, 8'd13, 4'hA, '{8'd15, 8'd5, 1'b0, 1'b0, 4'hA}, 0);
        idle();
        wait_drain(20);
        repeat (2) @(negedge CLK);
        chk("final_busy", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
